// File: rtl/satd_pkg.sv
// Shared constants and buffer-state type for the SATD block feeder.
// Optional SATD_FEED_LAST_EN users also rely on these types.
package satd_pkg;
   localparam int DEF_WIDTH      = 8;
   localparam int DEF_NUM_INPUTS = 8;
   localparam int DEF_NUM_ROWS   = 16;
   localparam int ROW_BITS       = DEF_WIDTH * DEF_NUM_INPUTS;
   localparam int BLK_BITS       = ROW_BITS * DEF_NUM_ROWS;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } buf_state_t;
endpackage

// File: rtl/satd_blk_buf.sv
// One block buffer: row-indexed write, EMPTY/FILLING/FULL state, flags.
// With SATD_FEED_LAST_EN it also remembers whether the block was closed early.
module satd_blk_buf
   import satd_pkg::*;
#(
   parameter  int ROW_W    = ROW_BITS,
   parameter  int NUM_ROWS = DEF_NUM_ROWS,
   localparam int IDX_W    = $clog2(NUM_ROWS),
   localparam int BLK_W    = ROW_W * NUM_ROWS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [ROW_W-1:0] wr_org,
   input  logic [ROW_W-1:0] wr_cur,
   input  logic             wr_close,
`ifdef SATD_FEED_LAST_EN
   input  logic             wr_short,
   output logic             short_blk,
`endif
   input  logic             rd_en,
   output logic             full,
   output logic             empty,
   output logic [BLK_W-1:0] org,
   output logic [BLK_W-1:0] cur
);
   buf_state_t state_reg, state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= EMPTY;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (rd_en)
         state_next = EMPTY;
      else if (wr_en)
         state_next = wr_close ? FULL : FILLING;
   end

   assign full  = (state_reg == FULL);
   assign empty = (state_reg == EMPTY);

   // Writing row 0 clears every other row, so an early-closed block is zero-filled.
   for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      logic [ROW_W-1:0] org_row_reg, cur_row_reg;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            org_row_reg <= '0;
            cur_row_reg <= '0;
         end else if (wr_en) begin
            if (wr_idx == IDX_W'(gi)) begin
               org_row_reg <= wr_org;
               cur_row_reg <= wr_cur;
            end else if (wr_idx == '0) begin
               org_row_reg <= '0;
               cur_row_reg <= '0;
            end
         end
      end

      assign org[BLK_W-1-gi*ROW_W -: ROW_W] = org_row_reg;
      assign cur[BLK_W-1-gi*ROW_W -: ROW_W] = cur_row_reg;
   end

`ifdef SATD_FEED_LAST_EN
   logic short_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   short_reg <= 1'b0;
      else if (wr_en && wr_close) short_reg <= wr_short;
   end

   assign short_blk = short_reg;
`endif
endmodule

// File: rtl/satd_block_feeder.sv
// Row-to-block feeder for SATD with a two-buffer ping-pong.
// Define SATD_FEED_LAST_EN to add in_last (early block close) and short_blk.
module satd_block_feeder
   import satd_pkg::*;
#(
   parameter  int WIDTH      = DEF_WIDTH,
   parameter  int NUM_INPUTS = DEF_NUM_INPUTS,
   parameter  int NUM_ROWS   = DEF_NUM_ROWS,
   localparam int ROW_W      = WIDTH * NUM_INPUTS,
   localparam int BLK_W      = ROW_W * NUM_ROWS,
   localparam int IDX_W      = $clog2(NUM_ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ROW_W-1:0] in_ORG,
   input  logic [ROW_W-1:0] in_CUR,
`ifdef SATD_FEED_LAST_EN
   input  logic             in_last,
   output logic             short_blk,
`endif
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic [BLK_W-1:0] ORG,
   output logic [BLK_W-1:0] CUR,
   output logic             busy
);
   logic             wr_sel_reg, rd_sel_reg;
   logic [IDX_W-1:0] row_cnt_reg;
   logic [1:0]       full, empty;
   logic [BLK_W-1:0] org_b [2];
   logic [BLK_W-1:0] cur_b [2];
   logic             wr_fire, rd_fire, last_row, close_row;

   assign in_ready  = !full[wr_sel_reg];
   assign blk_valid = full[rd_sel_reg];
   assign wr_fire   = in_valid && in_ready;
   assign rd_fire   = blk_valid && blk_ready;
   assign last_row  = (row_cnt_reg == IDX_W'(NUM_ROWS - 1));

`ifdef SATD_FEED_LAST_EN
   logic short_b [2];
   assign close_row = last_row || in_last;
   assign short_blk = short_b[rd_sel_reg];
`else
   assign close_row = last_row;
`endif

   for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      satd_blk_buf #(
         .ROW_W    (ROW_W),
         .NUM_ROWS (NUM_ROWS)
      ) u_buf (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (wr_fire && (wr_sel_reg == 1'(gi))),
         .wr_idx    (row_cnt_reg),
         .wr_org    (in_ORG),
         .wr_cur    (in_CUR),
         .wr_close  (close_row),
`ifdef SATD_FEED_LAST_EN
         .wr_short  (in_last && !last_row),
         .short_blk (short_b[gi]),
`endif
         .rd_en     (rd_fire && (rd_sel_reg == 1'(gi))),
         .full      (full[gi]),
         .empty     (empty[gi]),
         .org       (org_b[gi]),
         .cur       (cur_b[gi])
      );
   end

   assign ORG  = org_b[rd_sel_reg];
   assign CUR  = cur_b[rd_sel_reg];
   assign busy = !(empty[0] && empty[1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_sel_reg  <= 1'b0;
         rd_sel_reg  <= 1'b0;
         row_cnt_reg <= '0;
      end else begin
         if (wr_fire) begin
            row_cnt_reg <= close_row ? '0 : row_cnt_reg + IDX_W'(1);
            if (close_row) wr_sel_reg <= !wr_sel_reg;
         end
         if (rd_fire) rd_sel_reg <= !rd_sel_reg;
      end
   end
endmodule

// File: tb/tb_satd_block_feeder.sv
// Directed self-checking bench for satd_block_feeder (default 8x8x16 geometry).
// Covers SATD_FEED_LAST_EN when the macro is defined for the build.
module tb_satd_block_feeder;
   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_org, in_cur;
   logic          blk_valid;
   logic          blk_ready;
   logic [1023:0] org, cur;
   logic          busy;
`ifdef SATD_FEED_LAST_EN
   logic          in_last;
   logic          short_blk;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   satd_block_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ORG    (in_org),
      .in_CUR    (in_cur),
`ifdef SATD_FEED_LAST_EN
      .in_last   (in_last),
      .short_blk (short_blk),
`endif
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .ORG       (org),
      .CUR       (cur),
      .busy      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_blk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      int bad;
      logic [63:0] ro, re;
      bad = 0;
      for (int k = 15; k >= 0; k--)
         if (obs[1023-k*64 -: 64] !== exp[1023-k*64 -: 64]) bad = k;
      ro = obs[1023-bad*64 -: 64];
      re = exp[1023-bad*64 -: 64];
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: row %0d observed %h expected %h", tag, bad, ro, re);
      end
   endtask

   function automatic logic [63:0] row_org(input int r);
      logic [7:0] b;
      b = r[7:0];
      return {8{b}};
   endfunction

   function automatic logic [63:0] row_cur(input int r);
      logic [7:0] b;
      b = 8'hA5 ^ r[7:0];
      return {8{b}};
   endfunction

   function automatic logic [1023:0] mk_org(input int base, input int nrows);
      logic [1023:0] v;
      v = '0;
      for (int k = 0; k < nrows; k++) v[1023-k*64 -: 64] = row_org(base + k);
      return v;
   endfunction

   function automatic logic [1023:0] mk_cur(input int base, input int nrows);
      logic [1023:0] v;
      v = '0;
      for (int k = 0; k < nrows; k++) v[1023-k*64 -: 64] = row_cur(base + k);
      return v;
   endfunction

   // Presents one row, waits (bounded) for in_ready, then lets one edge transfer it.
   task automatic push_row(input logic [63:0] o, input logic [63:0] c);
      int n;
      in_org   = o;
      in_cur   = c;
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n == 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL push_row_timeout: in_ready observed %b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [1023:0] e_org, e_cur;
      rst       = 1'b1;
      in_valid  = 1'b0;
      blk_ready = 1'b0;
      in_org    = '0;
      in_cur    = '0;
`ifdef SATD_FEED_LAST_EN
      in_last   = 1'b0;
`endif
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_blk_valid", 64'(blk_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk_blk("rst_org", org, '0);
      chk_blk("rst_cur", cur, '0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // 1: constant rows, consumer always ready
      blk_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         push_row(64'h0101010101010101, 64'hFFFFFFFFFFFFFFFF);
         if (k == 14) chk("t1_early_valid", 64'(blk_valid), 64'd0);
      end
      e_org = {128{8'h01}};
      e_cur = '1;
      chk("t1_blk_valid", 64'(blk_valid), 64'd1);
      chk_blk("t1_org", org, e_org);
      chk_blk("t1_cur", cur, e_cur);
      chk("t1_busy", 64'(busy), 64'd1);
      tick();
      chk("t1_accepted", 64'(blk_valid), 64'd0);
      chk("t1_idle", 64'(busy), 64'd0);

      // 2: ramp rows, held while consumer stalls
      blk_ready = 1'b0;
      for (int k = 0; k < 16; k++) push_row(row_org(k), row_cur(k));
      chk("t2_blk_valid", 64'(blk_valid), 64'd1);
      chk("t2_org_top", org[1023:960], 64'h0000000000000000);
      chk("t2_org_bot", org[63:0], 64'h0F0F0F0F0F0F0F0F);
      chk_blk("t2_cur", cur, mk_cur(0, 16));
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_blk("t2_hold_org", org, mk_org(0, 16));
         chk("t2_hold_valid", 64'(blk_valid), 64'd1);
      end
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
      chk("t2_accepted", 64'(blk_valid), 64'd0);
      chk("t2_idle", 64'(busy), 64'd0);

      // 3: both buffers fill, back-pressure, single-cycle release
      for (int r = 0; r < 32; r++) push_row(row_org(r), row_cur(r));
      chk("t3_in_ready_low", 64'(in_ready), 64'd0);
      chk("t3_busy", 64'(busy), 64'd1);
      chk("t3_blk_valid", 64'(blk_valid), 64'd1);
      chk_blk("t3_org_a", org, mk_org(0, 16));
      in_org   = row_org(32);
      in_cur   = row_cur(32);
      in_valid = 1'b1;
      tick();
      tick();
      chk("t3_stalled", 64'(in_ready), 64'd0);
      chk_blk("t3_org_a_hold", org, mk_org(0, 16));
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
      chk("t3_in_ready_back", 64'(in_ready), 64'd1);
      chk("t3_blk_valid_b", 64'(blk_valid), 64'd1);
      chk_blk("t3_org_b", org, mk_org(16, 16));
      for (int r = 32; r < 48; r++) push_row(row_org(r), row_cur(r));
      chk("t3_in_ready_low2", 64'(in_ready), 64'd0);
      chk_blk("t3_cur_b", cur, mk_cur(16, 16));
      blk_ready = 1'b1;
      tick();
      chk_blk("t3_org_c", org, mk_org(32, 16));
      chk_blk("t3_cur_c", cur, mk_cur(32, 16));
      chk("t3_blk_valid_c", 64'(blk_valid), 64'd1);
      tick();
      blk_ready = 1'b0;
      chk("t3_drained", 64'(blk_valid), 64'd0);
      chk("t3_idle", 64'(busy), 64'd0);

      // 4: 64 rows back-to-back with consumer always ready
      blk_ready = 1'b1;
      for (int r = 0; r < 64; r++) begin
         in_org   = row_org(r);
         in_cur   = row_cur(r);
         in_valid = 1'b1;
         chk("t4_in_ready", 64'(in_ready), 64'd1);
         tick();
         chk("t4_blk_valid", 64'((r % 16) == 15), 64'(blk_valid));
         if ((r % 16) == 15) chk_blk("t4_org", org, mk_org(r - 15, 16));
      end
      in_valid = 1'b0;
      tick();
      chk("t4_idle", 64'(busy), 64'd0);

      // 5: reset with one block pending and a partial block in flight
      blk_ready = 1'b0;
      for (int r = 0; r < 24; r++) push_row(row_org(r), row_cur(r));
      chk("t5_pending", 64'(blk_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("t5_rst_blk_valid", 64'(blk_valid), 64'd0);
      chk("t5_rst_in_ready", 64'(in_ready), 64'd1);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk_blk("t5_rst_org", org, '0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      for (int r = 100; r < 116; r++) push_row(row_org(r), row_cur(r));
      chk("t5_blk_valid", 64'(blk_valid), 64'd1);
      chk_blk("t5_org", org, mk_org(100, 16));
      chk_blk("t5_cur", cur, mk_cur(100, 16));
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
      chk("t5_idle", 64'(busy), 64'd0);

`ifdef SATD_FEED_LAST_EN
      // 6: in_last on row 15 is a normal close
      for (int k = 0; k < 16; k++) begin
         in_last = (k == 15);
         push_row(row_org(40 + k), row_cur(40 + k));
      end
      in_last = 1'b0;
      chk("t6_full_short", 64'(short_blk), 64'd0);
      chk_blk("t6_full_org", org, mk_org(40, 16));
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
      // early close on row 3 into a buffer still holding older data
      for (int k = 0; k < 4; k++) begin
         in_last = (k == 3);
         push_row(row_org(60 + k), row_cur(60 + k));
      end
      in_last = 1'b0;
      chk("t6_short_valid", 64'(blk_valid), 64'd1);
      chk("t6_short_flag", 64'(short_blk), 64'd1);
      chk_blk("t6_short_org", org, mk_org(60, 4));
      chk_blk("t6_short_cur", cur, mk_cur(60, 4));
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
      for (int k = 0; k < 16; k++) push_row(row_org(70 + k), row_cur(70 + k));
      chk("t6_next_valid", 64'(blk_valid), 64'd1);
      chk("t6_next_short", 64'(short_blk), 64'd0);
      chk_blk("t6_next_org", org, mk_org(70, 16));
      blk_ready = 1'b1;
      tick();
      blk_ready = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
